// File: rtl/multiplier_axil_pkg.sv
// Shared constants, types and helpers for the AXI-Lite multiplier.
// Register offsets, CTRL bit positions, FSM states, byte-merge.
package multiplier_axil_pkg;

    localparam logic [1:0] REG_OPA    = 2'd0;
    localparam logic [1:0] REG_OPB    = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_RESULT = 2'd3;

    localparam int CTRL_START = 0;
    localparam int CTRL_BUSY  = 1;
    localparam int CTRL_DONE  = 2;
    localparam int CTRL_IE    = 3;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    function automatic logic [31:0] wmerge(
        input logic [31:0] old,
        input logic [31:0] wd,
        input logic [3:0]  ws
    );
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (ws[i]) r[8*i +: 8] = wd[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/mult_shift_add_core.sv
// Iterative shift-add multiplier, one multiplier bit per cycle.
// Runs exactly OP_W cycles after start; product holds until next run.
module mult_shift_add_core
    import multiplier_axil_pkg::*;
#(
    parameter int OP_W = 16
) (
    input  logic              clk,
    input  logic              aresetn,
    input  logic              start,
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic              busy,
    output logic              done_pulse,
    output logic [2*OP_W-1:0] product
);

    localparam int PW = 2 * OP_W;
    localparam int CW = (OP_W > 1) ? $clog2(OP_W) : 1;
    localparam logic [CW-1:0] LAST = CW'(OP_W - 1);

    state_t          state;
    state_t          state_nxt;
    logic [PW-1:0]   mcand;
    logic [PW-1:0]   acc;
    logic [PW-1:0]   acc_add;
    logic [OP_W-1:0] mplier;
    logic [CW-1:0]   cnt;

    assign acc_add = mplier[0] ? (acc + mcand) : acc;

    // FSM state register
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next state and status outputs
    always_comb begin
        state_nxt  = state;
        busy       = 1'b0;
        done_pulse = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == LAST) begin
                    done_pulse = 1'b1;
                    state_nxt  = IDLE;
                end
            end
        endcase
    end

    // Operand latch, accumulate/shift, publish product on the last step
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
            product <= '0;
        end else if (state == IDLE && start) begin
            mcand  <= PW'(a);
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
        end else if (busy) begin
            acc    <= acc_add;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
            if (done_pulse) product <= acc_add;
        end
    end

endmodule

// File: rtl/multiplier_axil_regs.sv
// AXI4-Lite register file wrapping the shift-add multiplier core.
// Optional MULT_IRQ_EN adds the IE bit, DONE write-1-to-clear and irq.
module multiplier_axil_regs
    import multiplier_axil_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int OP_W               = 16
) (
    input  logic                            s00_axi_aclk,
    input  logic                            s00_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [2:0]                      s00_axi_awprot,
    input  logic                            s00_axi_awvalid,
    output logic                            s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
    input  logic                            s00_axi_wvalid,
    output logic                            s00_axi_wready,
    output logic [1:0]                      s00_axi_bresp,
    output logic                            s00_axi_bvalid,
    input  logic                            s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [2:0]                      s00_axi_arprot,
    input  logic                            s00_axi_arvalid,
    output logic                            s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                      s00_axi_rresp,
    output logic                            s00_axi_rvalid,
    input  logic                            s00_axi_rready
`ifdef MULT_IRQ_EN
    ,
    output logic                            irq
`endif
);

    localparam int PW = 2 * OP_W;

    logic [OP_W-1:0] opa;
    logic [OP_W-1:0] opb;
    logic            ie;
    logic            done;
    logic            busy;
    logic            done_pulse;
    logic            start;
    logic [PW-1:0]   product;
    logic [1:0]      wa;
    logic [1:0]      ra;
    logic            wr_en;
    logic            rd_en;
    logic            ctrl_wr;
    logic [31:0]     opa_m;
    logic [31:0]     opb_m;
    logic [31:0]     rd_word;
    logic            unused_ok;

    assign wa      = s00_axi_awaddr[3:2];
    assign ra      = s00_axi_araddr[3:2];
    assign wr_en   = s00_axi_aresetn & s00_axi_awvalid
                   & s00_axi_wvalid & ~s00_axi_bvalid;
    assign rd_en   = s00_axi_aresetn & s00_axi_arvalid
                   & ~s00_axi_rvalid;
    assign ctrl_wr = wr_en && wa == REG_CTRL && s00_axi_wstrb[0];
    assign start   = ctrl_wr && s00_axi_wdata[CTRL_START] && !busy;
    assign opa_m   = wmerge(32'(opa), s00_axi_wdata, s00_axi_wstrb);
    assign opb_m   = wmerge(32'(opb), s00_axi_wdata, s00_axi_wstrb);

    assign s00_axi_awready = wr_en;
    assign s00_axi_wready  = wr_en;
    assign s00_axi_arready = rd_en;
    assign s00_axi_bresp   = RESP_OKAY;
    assign s00_axi_rresp   = RESP_OKAY;

    assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot,
                         s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

    mult_shift_add_core #(
        .OP_W (OP_W)
    ) u_core (
        .clk        (s00_axi_aclk),
        .aresetn    (s00_axi_aresetn),
        .start      (start),
        .a          (opa),
        .b          (opb),
        .busy       (busy),
        .done_pulse (done_pulse),
        .product    (product)
    );

    // Operand registers, frozen while a multiply is running
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            opa <= '0;
            opb <= '0;
        end else if (wr_en && !busy) begin
            if (wa == REG_OPA) opa <= opa_m[OP_W-1:0];
            if (wa == REG_OPB) opb <= opb_m[OP_W-1:0];
        end
    end

`ifdef MULT_IRQ_EN
    // Interrupt enable, writable at any time
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) ie <= 1'b0;
        else if (ctrl_wr)     ie <= s00_axi_wdata[CTRL_IE];
    end

    assign irq = done & ie;

    // Sticky DONE: completion wins, then START or W1C clear it
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) done <= 1'b0;
        else if (done_pulse)  done <= 1'b1;
        else if (start)       done <= 1'b0;
        else if (ctrl_wr && s00_axi_wdata[CTRL_DONE]) done <= 1'b0;
    end
`else
    assign ie = 1'b0;

    // Sticky DONE: set on completion, cleared by a new START
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) done <= 1'b0;
        else if (done_pulse)  done <= 1'b1;
        else if (start)       done <= 1'b0;
    end
`endif

    // Read mux over current register values
    always_comb begin
        rd_word = '0;
        unique case (ra)
            REG_OPA:    rd_word = 32'(opa);
            REG_OPB:    rd_word = 32'(opb);
            REG_CTRL:   rd_word = {28'd0, ie, done, busy, 1'b0};
            REG_RESULT: rd_word = 32'(product);
        endcase
    end

    // Write response channel
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn)    s00_axi_bvalid <= 1'b0;
        else if (wr_en)          s00_axi_bvalid <= 1'b1;
        else if (s00_axi_bready) s00_axi_bvalid <= 1'b0;
    end

    // Read data channel, data held until accepted
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            s00_axi_rvalid <= 1'b0;
            s00_axi_rdata  <= '0;
        end else if (rd_en) begin
            s00_axi_rvalid <= 1'b1;
            s00_axi_rdata  <= rd_word;
        end else if (s00_axi_rready) begin
            s00_axi_rvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_multiplier_axil_regs.sv
// Self-checking bench for multiplier_axil_regs.
// Per-cycle reference model plus directed and random AXI traffic.
module tb_multiplier_axil_regs;

    localparam int OP_W = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [3:0]  araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
`ifdef MULT_IRQ_EN
    logic        irq;
`endif

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    multiplier_axil_regs dut (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (rst_n),
        .s00_axi_awaddr  (awaddr),
        .s00_axi_awprot  (awprot),
        .s00_axi_awvalid (awvalid),
        .s00_axi_awready (awready),
        .s00_axi_wdata   (wdata),
        .s00_axi_wstrb   (wstrb),
        .s00_axi_wvalid  (wvalid),
        .s00_axi_wready  (wready),
        .s00_axi_bresp   (bresp),
        .s00_axi_bvalid  (bvalid),
        .s00_axi_bready  (bready),
        .s00_axi_araddr  (araddr),
        .s00_axi_arprot  (arprot),
        .s00_axi_arvalid (arvalid),
        .s00_axi_arready (arready),
        .s00_axi_rdata   (rdata),
        .s00_axi_rresp   (rresp),
        .s00_axi_rvalid  (rvalid),
        .s00_axi_rready  (rready)
`ifdef MULT_IRQ_EN
        ,
        .irq             (irq)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: architectural register state plus a run countdown
    logic [15:0] m_opa, m_opb, m_a, m_b;
    logic        m_ie, m_done;
    logic [31:0] m_result, m_rdata;
    int          m_left;
    logic        m_bvalid, m_rvalid;
    logic        w_fire = 1'b0;
    logic        r_fire = 1'b0;

    function automatic logic [31:0] m_read(input logic [3:0] addr);
        case (addr[3:2])
            2'd0:    return {16'd0, m_opa};
            2'd1:    return {16'd0, m_opb};
            2'd2:    return {28'd0, m_ie, m_done, (m_left != 0), 1'b0};
            default: return m_result;
        endcase
    endfunction

    function automatic logic [15:0] merge16(input logic [15:0] old,
                                            input logic [31:0] d,
                                            input logic [3:0]  s);
        logic [31:0] t;
        t = {16'd0, old};
        for (int i = 0; i < 4; i++) if (s[i]) t[8*i +: 8] = d[8*i +: 8];
        return t[15:0];
    endfunction

    // Compare every output each cycle, then advance the model
    always @(negedge clk) begin : model
        logic ea, er, busy_now;
        if (!rst_n) begin
            m_opa = 0; m_opb = 0; m_a = 0; m_b = 0;
            m_ie = 0; m_done = 0; m_result = 0; m_rdata = 0;
            m_left = 0; m_bvalid = 0; m_rvalid = 0;
        end
        ea = rst_n && awvalid && wvalid && !m_bvalid;
        er = rst_n && arvalid && !m_rvalid;
        chk("awready", awready, ea);
        chk("wready", wready, ea);
        chk("bvalid", bvalid, m_bvalid);
        chk("bresp", bresp, 0);
        chk("arready", arready, er);
        chk("rvalid", rvalid, m_rvalid);
        if (rvalid || !rst_n) begin
            chk("rdata", rdata, m_rdata);
            chk("rresp", rresp, 0);
        end
`ifdef MULT_IRQ_EN
        chk("irq", irq, m_done & m_ie);
`endif
        w_fire = ea;
        r_fire = er;
        if (rst_n) begin
            busy_now = (m_left != 0);
            if (m_bvalid && bready) m_bvalid = 0;
            if (ea) m_bvalid = 1;
            if (m_rvalid && rready) m_rvalid = 0;
            if (er) begin
                m_rvalid = 1;
                m_rdata  = m_read(araddr);
            end
            if (ea) begin
                case (awaddr[3:2])
                    2'd0: if (!busy_now) m_opa = merge16(m_opa, wdata, wstrb);
                    2'd1: if (!busy_now) m_opb = merge16(m_opb, wdata, wstrb);
                    2'd2: if (wstrb[0]) begin
`ifdef MULT_IRQ_EN
                        m_ie = wdata[3];
                        if (wdata[2]) m_done = 0;
`endif
                        if (wdata[0] && !busy_now) begin
                            m_a = m_opa;
                            m_b = m_opb;
                            m_left = OP_W;
                            m_done = 0;
                        end
                    end
                    default: ;
                endcase
            end
            if (busy_now) begin
                m_left--;
                if (m_left == 0) begin
                    m_result = 32'(m_a) * 32'(m_b);
                    m_done = 1;
                end
            end
        end
    end

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] d,
                             input logic [3:0] s);
        bit ok;
        ok = 0;
        @(posedge clk); #1;
        awaddr = addr; awvalid = 1; awprot = 0;
        wdata = d; wstrb = s; wvalid = 1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (awready && wready) ok = 1;
        end
        chk("write_handshake", ok, 1);
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0;
    endtask

    task automatic axi_read(input logic [3:0] addr, output logic [31:0] d);
        bit ok;
        ok = 0;
        d = 'x;
        @(posedge clk); #1;
        araddr = addr; arvalid = 1; arprot = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (arready) ok = 1;
        end
        chk("read_handshake", ok, 1);
        @(posedge clk); #1;
        arvalid = 0;
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (rvalid) begin
                ok = 1;
                d = rdata;
            end
        end
        chk("read_data_wait", ok, 1);
    endtask

    task automatic wait_done(output bit saw_busy);
        logic [31:0] d;
        bit fin;
        fin = 0;
        saw_busy = 0;
        for (int i = 0; i < 100 && !fin; i++) begin
            axi_read(4'h8, d);
            if (d[1]) saw_busy = 1;
            if (!d[1] && d[2]) fin = 1;
        end
        chk("poll_done", fin, 1);
    endtask

    function automatic logic [31:0] rand_data();
        case ($urandom_range(3))
            0:       return $urandom;
            1:       return 32'($urandom_range(255));
            2:       return 32'($urandom_range(15));
            default: return 32'h0000FFFF;
        endcase
    endfunction

    task automatic rnd_step(input bit allow_new);
        @(posedge clk); #1;
        if (w_fire) begin
            awvalid = 0;
            wvalid  = 0;
        end
        if (r_fire) arvalid = 0;
        if (!awvalid && (allow_new ? ($urandom_range(3) == 0) : wvalid)) begin
            awvalid = 1;
            awaddr  = 4'($urandom_range(3) << 2);
            awprot  = 3'($urandom);
        end
        if (!wvalid && (allow_new ? ($urandom_range(3) == 0) : awvalid)) begin
            wvalid = 1;
            wdata  = rand_data();
            wstrb  = ($urandom_range(3) == 0) ? 4'($urandom) : 4'hF;
        end
        if (!arvalid && allow_new && $urandom_range(2) == 0) begin
            arvalid = 1;
            araddr  = 4'($urandom_range(3) << 2);
            arprot  = 3'($urandom);
        end
        bready = allow_new ? ($urandom_range(1) == 1) : 1'b1;
        rready = allow_new ? ($urandom_range(3) != 0) : 1'b1;
    endtask

    initial begin
        #2_000_000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        logic [31:0] d;
        bit sb;
        rst_n = 0;
        awaddr = 0; awprot = 0; awvalid = 0;
        wdata = 0; wstrb = 0; wvalid = 0; bready = 1;
        araddr = 0; arprot = 0; arvalid = 0; rready = 1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;

        axi_read(4'h0, d); chk("reset_opa", d, 32'h0);
        axi_read(4'h4, d); chk("reset_opb", d, 32'h0);
        axi_read(4'h8, d); chk("reset_ctrl", d, 32'h0);
        axi_read(4'hC, d); chk("reset_result", d, 32'h0);

        axi_write(4'h0, 32'd3, 4'hF);
        axi_write(4'h4, 32'd5, 4'hF);
        axi_write(4'h8, 32'd1, 4'hF);
        wait_done(sb);
        chk("3x5_saw_busy", sb, 1);
        axi_read(4'h8, d); chk("3x5_ctrl", d, 32'h4);
        axi_read(4'hC, d); chk("3x5_result", d, 32'h0000000F);

        axi_write(4'h0, 32'hFFFF, 4'hF);
        axi_write(4'h4, 32'hFFFF, 4'hF);
        axi_write(4'h8, 32'd1, 4'hF);
        wait_done(sb);
        axi_read(4'hC, d); chk("max_result", d, 32'hFFFE0001);
        axi_write(4'h0, 32'h0, 4'hF);
        axi_write(4'h8, 32'd1, 4'hF);
        wait_done(sb);
        axi_read(4'hC, d); chk("zero_result", d, 32'h0);

        axi_write(4'h0, 32'h1234, 4'hF);
        axi_write(4'h0, 32'h0000ABCD, 4'b0001);
        axi_read(4'h0, d); chk("wstrb_opa", d, 32'h000012CD);

        axi_write(4'h4, 32'h10, 4'hF);
        axi_write(4'h8, 32'd1, 4'hF);
        axi_write(4'h0, 32'd7, 4'hF);
        axi_write(4'h8, 32'd1, 4'hF);
        wait_done(sb);
        axi_read(4'hC, d); chk("busy_result", d, 32'h00012CD0);
        axi_read(4'h0, d); chk("busy_opa", d, 32'h000012CD);
        repeat (30) @(posedge clk);
        axi_read(4'h8, d); chk("single_done", d, 32'h4);

        for (int c = 0; c < 3000; c++) rnd_step(1'b1);
        for (int c = 0; c < 300; c++) rnd_step(1'b0);
        #1;
        awvalid = 0; wvalid = 0; arvalid = 0;
        bready = 1; rready = 1;
        repeat (4) @(posedge clk);

        axi_write(4'h8, 32'h0, 4'hF);
        repeat (OP_W + 4) @(posedge clk);
        axi_write(4'h0, 32'd9, 4'hF);
        axi_write(4'h4, 32'd9, 4'hF);
        axi_write(4'h8, 32'd1, 4'hF);
        wait_done(sb);
        axi_read(4'hC, d); chk("9x9_result", d, 32'h51);
        axi_write(4'h8, 32'd1, 4'hF);
        repeat (5) @(posedge clk);
        #1 rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        axi_read(4'h8, d); chk("midrun_ctrl", d, 32'h0);
        axi_read(4'hC, d); chk("midrun_result", d, 32'h0);
        axi_read(4'h0, d); chk("midrun_opa", d, 32'h0);
        axi_write(4'h0, 32'd6, 4'hF);
        axi_write(4'h4, 32'd7, 4'hF);
        axi_write(4'h8, 32'd1, 4'hF);
        wait_done(sb);
        axi_read(4'hC, d); chk("6x7_result", d, 32'h2A);

`ifdef MULT_IRQ_EN
        axi_write(4'h8, 32'h8, 4'hF);
        axi_write(4'h8, 32'h9, 4'hF);
        wait_done(sb);
        @(negedge clk);
        chk("irq_high", irq, 1);
        axi_write(4'h8, 32'hC, 4'hF);
        @(negedge clk);
        chk("irq_low", irq, 0);
        axi_read(4'h8, d); chk("w1c_ctrl", d, 32'h8);
`endif

        repeat (4) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/multiplier_axil_regs.md
Name: multiplier_axil_regs

Overview:
- AXI4-Lite slave register file plus iterative multiplier datapath.
- Sits directly downstream of the AXI master in the multiplier IP block design and consumes its single-beat write/read transfers.
- Software writes two operands, sets START, polls STATUS, then reads RESULT.
- Multiplication is shift-add, one operand bit per cycle.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, AXI data width; only 32 supported.
- C_S_AXI_ADDR_WIDTH, 4, byte address width; 4 word registers.
- OP_W, 16, unsigned operand width; 2*OP_W must be <= 32.

Ports:
- s00_axi_aclk  in  1  clock; all logic on rising edge.
- s00_axi_aresetn  in  1  asynchronous active-low reset.
- s00_axi_awaddr  in  4  write address.
- s00_axi_awprot  in  3  ignored.
- s00_axi_awvalid / s00_axi_awready  in / out  1  write-address handshake.
- s00_axi_wdata  in  32  write data.
- s00_axi_wstrb  in  4  byte enables.
- s00_axi_wvalid / s00_axi_wready  in / out  1  write-data handshake.
- s00_axi_bresp  out  2  always 2'b00 (OKAY).
- s00_axi_bvalid / s00_axi_bready  out / in  1  write-response handshake.
- s00_axi_araddr  in  4  read address.
- s00_axi_arprot  in  3  ignored.
- s00_axi_arvalid / s00_axi_arready  in / out  1  read-address handshake.
- s00_axi_rdata  out  32  read data.
- s00_axi_rresp  out  2  always 2'b00.
- s00_axi_rvalid / s00_axi_rready  out / in  1  read-data handshake.
- irq  out  1  present only with MULT_IRQ_EN.

Behaviour:
- Reset (async assert, sync release): all outputs 0; all registers 0; FSM IDLE.
- Register map (addr[3:2]):
  - 0x0 OPA: RW, bits [OP_W-1:0]; upper bits read 0.
  - 0x4 OPB: RW, same layout as OPA.
  - 0x8 CTRL: bit0 START (write-1 pulse, reads 0); bit1 BUSY (RO); bit2 DONE (RO, sticky); bit3 IE (RW).
  - 0xC RESULT: RO, 2*OP_W-bit product, zero-extended.
- Write channel:
  - awready and wready assert together for exactly one cycle when awvalid && wvalid && !bvalid.
  - Register update happens in that same handshake cycle.
  - bvalid rises the next cycle and holds until bready.
  - A master presenting AW without W (or W without AW) waits; no buffering.
- wstrb is honoured per byte on OPA, OPB and CTRL.IE.
- Writes to RO fields and unmapped bits are dropped; response is still OKAY.
- Read channel:
  - arready pulses for one cycle when arvalid && !rvalid.
  - rdata is captured from the current register values in the handshake cycle.
  - rvalid rises the next cycle; rdata holds stable until rready.
- FSM IDLE -> RUN on an accepted CTRL write with wdata[0]=1 and wstrb[0]=1:
  - Latches OPA/OPB into the core.
  - Clears DONE and RESULT accumulator.
  - BUSY=1 from the next cycle.
- RUN, per cycle:
  - If multiplier LSB=1, acc += multiplicand.
  - Multiplicand <<= 1, multiplier >>= 1, counter++.
- After exactly OP_W RUN cycles: RESULT=acc, BUSY=0, DONE=1, FSM -> IDLE.
  - START accepted at cycle T gives DONE visible at T+1+OP_W.
- While BUSY:
  - START writes are ignored.
  - OPA/OPB writes are ignored.
  - Responses are still OKAY.
- RESULT holds its last value until the next completion.
- A read of CTRL in the completion cycle returns the pre-update value (BUSY=1, DONE=0).
- Simultaneous AW/W and AR handshakes are independent; both are accepted in the same cycle.
- Reset mid-RUN: immediate return to IDLE with all state cleared.

Optional Feature:
- Macro: MULT_IRQ_EN.
- Defined:
  - irq port exists; irq = DONE & IE (level).
  - Cleared by writing CTRL bit2=1 (W1C on DONE) or by a new START.
- Undefined:
  - No irq port; IE reads 0.
  - DONE is cleared only by START.

Decomposition:
- Package multiplier_axil_pkg holds:
  - Register offset localparams (OPA, OPB, CTRL, RESULT).
  - CTRL bit indices.
  - FSM state enum {IDLE, RUN}.
  - OKAY response constant.
- Sub-module mult_shift_add_core holds:
  - FSM, counter and datapath.
  - Ports: clk, aresetn, start, a, b, busy, done_pulse, product.
- Top keeps the AXI handshakes and registers.

Test Plan:
- Reset release, then read 0x0/0x4/0x8/0xC -> all 0x00000000, rresp=OKAY.
- Write OPA=3, OPB=5, CTRL=1; poll 0x8 -> BUSY for 16 cycles, then CTRL=0x4 and RESULT=0x0000000F.
- OPA=OPB=0xFFFF, START -> RESULT=0xFFFE0001; then OPA=0, START -> RESULT=0.
- OPA=0x1234, then write 0x0000ABCD with wstrb=4'b0001 -> OPA reads 0x000012CD.
- During BUSY, write OPA=7 and START -> OPA unchanged, single completion, result from the original operands.
- Assert aresetn low mid-RUN -> BUSY/DONE/RESULT 0 immediately; a fresh 6x7 run gives 0x2A. With MULT_IRQ_EN and IE=1, irq rises with DONE and falls after a W1C write of 0x4.
